// File: rtl/grf_scoreboard.sv
// grf_scoreboard: register-read hazard tracker for the pipelined CPU.
// Each GPR 1..31 has a pending-write counter. An accepted D-stage issue of a
// writing instruction increments its destination counter; the W-stage GRF
// write decrements it. D stalls while a source register has a pending write
// or the destination counter is at MAX_PEND.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   issue_en/we/a3      - D-stage issue attempt, GRF write flag, destination
//   rs_use/addr, rt_*   - source operands read by the issuing instruction
//   wb_en, wb_a3        - GRF write port in W (WE / A3)
//   stall               - D must hold, issue not accepted (combinational)
//   rs_busy, rt_busy    - source operand has a pending write
//   any_pending         - some counter is nonzero (registered state only)
//   err                 - sticky: a retire found its counter already at 0

// One pending-write counter. uflow flags a retire that had nothing to match.
module grf_sb_cnt #(
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] cnt,
  output logic          uflow
);
  assign uflow = dec && (cnt == '0);

  always_ff @(posedge clk) begin
    if (reset) cnt <= '0;
    else begin
      unique case ({inc, dec})
        2'b10: cnt <= cnt + CW'(1);
        2'b01: if (cnt != '0) cnt <= cnt - CW'(1);
        // Issue and retire together cancel, except at 0 where the retire is
        // spurious: the issue still counts, the retire is dropped.
        2'b11: if (cnt == '0) cnt <= CW'(1);
        default: ;
      endcase
    end
  end
endmodule

module grf_scoreboard #(
  parameter int MAX_PEND = 3,
  parameter int CW       = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       issue_en,
  input  logic       issue_we,
  input  logic [4:0] issue_a3,
  input  logic       rs_use,
  input  logic [4:0] rs_addr,
  input  logic       rt_use,
  input  logic [4:0] rt_addr,
  input  logic       wb_en,
  input  logic [4:0] wb_a3,
  output logic       stall,
  output logic       rs_busy,
  output logic       rt_busy,
  output logic       any_pending,
  output logic       err
);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_PEND);

  logic [31:0][CW-1:0] cnt;
  logic [31:1]         inc, dec, uflow;
  logic                full, acc, ret;

  // $0 is never tracked.
  assign cnt[0] = '0;

  assign rs_busy = rs_use && (rs_addr != 5'd0) && (cnt[rs_addr] != '0);
  assign rt_busy = rt_use && (rt_addr != 5'd0) && (cnt[rt_addr] != '0);
  assign full    = issue_we && (issue_a3 != 5'd0) && (cnt[issue_a3] == MAX_C);
  assign stall   = issue_en && (rs_busy || rt_busy || full);
  assign acc     = issue_en && !stall && issue_we && (issue_a3 != 5'd0);
  assign ret     = wb_en && (wb_a3 != 5'd0);

  assign any_pending = |cnt;

  for (genvar r = 1; r < 32; r++) begin : g_reg
    assign inc[r] = acc && (issue_a3 == 5'(r));
    assign dec[r] = ret && (wb_a3 == 5'(r));
    grf_sb_cnt #(.CW(CW)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (inc[r]),
      .dec   (dec[r]),
      .cnt   (cnt[r]),
      .uflow (uflow[r])
    );
  end

  always_ff @(posedge clk) begin
    if (reset)       err <= 1'b0;
    else if (|uflow) err <= 1'b1;
  end
endmodule

// File: tb/tb_grf_scoreboard.sv
// Bench for grf_scoreboard: a table of hand-derived per-cycle vectors covering
// reset, RAW stall, $0, full and simultaneous issue/retire, underflow, then a
// random traffic run checked against a small behavioural model. Expected
// outputs are queued when a cycle is driven and popped when it is sampled.
module tb_grf_scoreboard;
  localparam int MAX_PEND = 3;
  localparam int CW       = 2;

  logic clk = 1'b0;
  logic reset, issue_en, issue_we, rs_use, rt_use, wb_en;
  logic [4:0] issue_a3, rs_addr, rt_addr, wb_a3;
  logic stall, rs_busy, rt_busy, any_pending, err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  grf_scoreboard #(.MAX_PEND(MAX_PEND), .CW(CW)) dut (
    .clk(clk), .reset(reset),
    .issue_en(issue_en), .issue_we(issue_we), .issue_a3(issue_a3),
    .rs_use(rs_use), .rs_addr(rs_addr), .rt_use(rt_use), .rt_addr(rt_addr),
    .wb_en(wb_en), .wb_a3(wb_a3),
    .stall(stall), .rs_busy(rs_busy), .rt_busy(rt_busy),
    .any_pending(any_pending), .err(err)
  );

  // exp = {stall, rs_busy, rt_busy, any_pending, err} during the cycle;
  // cr != 0 also checks cnt[cr] == cv (state held during the cycle).
  typedef struct {
    logic rst, ien, iwe; logic [4:0] a3;
    logic rsu; logic [4:0] rsa; logic rtu; logic [4:0] rta;
    logic wbe; logic [4:0] wba;
    logic [4:0] exp; logic [4:0] cr; int cv;
  } vec_t;

  vec_t       tbl[$];
  logic [4:0] sb[$];

  function automatic vec_t mk(input logic rst, ien, iwe, input int a3,
                              input logic rsu, input int rsa, input logic rtu, input int rta,
                              input logic wbe, input int wba, input logic [4:0] exp,
                              input int cr = 0, input int cv = 0);
    vec_t v;
    v.rst = rst; v.ien = ien; v.iwe = iwe; v.a3 = 5'(a3);
    v.rsu = rsu; v.rsa = 5'(rsa); v.rtu = rtu; v.rta = 5'(rta);
    v.wbe = wbe; v.wba = 5'(wba); v.exp = exp; v.cr = 5'(cr); v.cv = cv;
    return v;
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    reset = v.rst; issue_en = v.ien; issue_we = v.iwe; issue_a3 = v.a3;
    rs_use = v.rsu; rs_addr = v.rsa; rt_use = v.rtu; rt_addr = v.rta;
    wb_en = v.wbe; wb_a3 = v.wba;
  endtask

  // Drive one cycle, sample at the falling edge, then let the rising edge pass.
  task automatic run_vec(input vec_t v, input string nm);
    logic [4:0] e;
    drive(v);
    sb.push_back(v.exp);
    @(negedge clk);
    e = sb.pop_front();
    check({nm, " outs"}, {stall, rs_busy, rt_busy, any_pending, err}, e);
    if (v.cr != 5'd0) check($sformatf("%s cnt[%0d]", nm, v.cr), dut.cnt[v.cr], v.cv);
    @(posedge clk); #1;
  endtask

  // Behavioural model for the random phase.
  int   m[32];
  logic merr;

  initial begin
    vec_t v;
    drive(mk(1, 0,0,0, 0,0, 0,0, 0,0, 5'b0));
    @(posedge clk); #1;

    // Reset mid-operation
    tbl.push_back(mk(0, 0,0,0, 1,3, 1,7, 0,0, 5'b00000));        // reset state
    tbl.push_back(mk(0, 1,1,3, 0,0, 0,0, 0,0, 5'b00000));
    tbl.push_back(mk(0, 1,1,3, 0,0, 0,0, 0,0, 5'b00010, 3, 1));
    tbl.push_back(mk(0, 1,1,7, 0,0, 0,0, 0,0, 5'b00010, 3, 2));
    tbl.push_back(mk(0, 0,0,0, 1,3, 1,7, 0,0, 5'b01110, 7, 1));
    tbl.push_back(mk(1, 1,1,3, 1,3, 0,0, 1,3, 5'b11010, 3, 2));  // reset beats issue/retire
    tbl.push_back(mk(0, 1,0,0, 1,3, 1,7, 0,0, 5'b00000, 3, 0));
    // Read-after-write stall on $8
    tbl.push_back(mk(0, 1,1,8, 0,0, 0,0, 0,0, 5'b00000));
    tbl.push_back(mk(0, 1,0,0, 1,8, 0,0, 0,0, 5'b11010));
    tbl.push_back(mk(0, 1,0,0, 1,8, 0,0, 0,0, 5'b11010));
    tbl.push_back(mk(0, 1,0,0, 1,8, 0,0, 1,8, 5'b11010));        // no same-cycle bypass
    tbl.push_back(mk(0, 1,0,0, 1,8, 0,0, 0,0, 5'b00000, 8, 0));
    // Register 0
    tbl.push_back(mk(0, 1,1,0, 1,0, 0,0, 0,0, 5'b00000));
    tbl.push_back(mk(0, 1,1,0, 1,0, 1,0, 0,0, 5'b00000));
    tbl.push_back(mk(0, 1,1,0, 1,0, 0,0, 0,0, 5'b00000));
    tbl.push_back(mk(0, 0,0,0, 1,0, 0,0, 1,0, 5'b00000));
    tbl.push_back(mk(0, 0,0,0, 0,0, 0,0, 0,0, 5'b00000));
    // Full on $9
    tbl.push_back(mk(0, 1,1,9, 0,0, 0,0, 0,0, 5'b00000));
    tbl.push_back(mk(0, 1,1,9, 0,0, 0,0, 0,0, 5'b00010));
    tbl.push_back(mk(0, 1,1,9, 0,0, 0,0, 0,0, 5'b00010));
    tbl.push_back(mk(0, 1,1,9, 0,0, 0,0, 0,0, 5'b10010, 9, 3));
    tbl.push_back(mk(0, 1,1,9, 0,0, 0,0, 1,9, 5'b10010, 9, 3));  // still full; retire lands
    tbl.push_back(mk(0, 1,1,9, 0,0, 0,0, 0,0, 5'b00010, 9, 2));  // held issue accepted
    tbl.push_back(mk(0, 0,0,0, 0,0, 0,0, 1,9, 5'b00010, 9, 3));
    tbl.push_back(mk(0, 0,0,0, 0,0, 0,0, 1,9, 5'b00010));
    tbl.push_back(mk(0, 0,0,0, 0,0, 0,0, 1,9, 5'b00010));
    tbl.push_back(mk(0, 0,0,0, 0,0, 0,0, 0,0, 5'b00000, 9, 0));
    // Simultaneous issue and retire
    tbl.push_back(mk(0, 1,1,4, 0,0, 0,0, 0,0, 5'b00000));
    tbl.push_back(mk(0, 1,1,4, 0,0, 0,0, 1,4, 5'b00010, 4, 1));
    tbl.push_back(mk(0, 0,0,0, 0,0, 0,0, 0,0, 5'b00010, 4, 1));
    tbl.push_back(mk(0, 0,0,0, 0,0, 0,0, 1,4, 5'b00010));
    tbl.push_back(mk(0, 1,1,12, 0,0, 0,0, 1,12, 5'b00000, 12, 0));
    tbl.push_back(mk(0, 0,0,0, 1,12, 0,0, 0,0, 5'b01011, 12, 1));
    tbl.push_back(mk(0, 0,0,0, 0,0, 0,0, 1,12, 5'b00011));
    tbl.push_back(mk(0, 0,0,0, 0,0, 0,0, 0,0, 5'b00001, 12, 0));
    // Underflow on $20
    tbl.push_back(mk(1, 0,0,0, 0,0, 0,0, 0,0, 5'b00001));
    tbl.push_back(mk(0, 0,0,0, 0,0, 0,0, 1,20, 5'b00000));
    for (int i = 0; i < 10; i++)
      tbl.push_back(mk(0, 0,0,0, 1,20, 0,0, 0,0, 5'b00001, 20, 0));
    tbl.push_back(mk(1, 0,0,0, 0,0, 0,0, 0,0, 5'b00001));
    tbl.push_back(mk(0, 0,0,0, 0,0, 0,0, 0,0, 5'b00000));

    for (int i = 0; i < tbl.size(); i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Random traffic on a few registers, state known clear at this point.
    foreach (m[i]) m[i] = 0;
    merr = 1'b0;
    for (int n = 0; n < 300; n++) begin
      logic rsb, rtb, full, st, acc, ret, anyp;
      v = mk($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1),
             $urandom_range(0, 4), $urandom_range(0, 1), $urandom_range(0, 4),
             $urandom_range(0, 1), $urandom_range(0, 4), $urandom_range(0, 2) == 0,
             $urandom_range(0, 4), 5'b0);
      rsb  = v.rsu && v.rsa != 0 && m[v.rsa] != 0;
      rtb  = v.rtu && v.rta != 0 && m[v.rta] != 0;
      full = v.iwe && v.a3 != 0 && m[v.a3] == MAX_PEND;
      st   = v.ien && (rsb || rtb || full);
      acc  = v.ien && !st && v.iwe && v.a3 != 0;
      ret  = v.wbe && v.wba != 0;
      anyp = 1'b0;
      foreach (m[i]) if (m[i] != 0) anyp = 1'b1;
      v.exp = {st, rsb, rtb, anyp, merr};
      run_vec(v, $sformatf("rnd%0d", n));
      if (v.rst) begin
        foreach (m[i]) m[i] = 0;
        merr = 1'b0;
      end else if (acc && ret && v.a3 == v.wba) begin
        if (m[v.a3] == 0) begin m[v.a3] = 1; merr = 1'b1; end
      end else begin
        if (acc) m[v.a3]++;
        if (ret) begin
          if (m[v.wba] > 0) m[v.wba]--;
          else merr = 1'b1;
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
